mul_div_hilo_unit: RTL and testbench

MUL_DIV_HILO_UNIT -- requirements
Module: mul_div_hilo_unit

---
 rtl/mdu_pkg.sv | 41 ++++
 rtl/mdu_divider.sv | 72 +++++++
 rtl/mul_div_hilo_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_mul_div_hilo_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the multiply/divide HI/LO unit:
//               operation encodings, FSM state encoding, default WIDTH and
//               a helper that says which operations use signed operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam int c_DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_MADD  = 3'b010,
        OP_MSUB  = 3'b011,
        OP_DIV   = 3'b100,
        OP_DIVU  = 3'b101,
        OP_MTHI  = 3'b110,
        OP_MTLO  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Operations whose operands are two's-complement and need magnitude
    // conversion on entry plus a sign fixup on exit.
    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_divider.sv
// ============================================================================
// Module      : mdu_divider
// Description : Unsigned restoring divider, one quotient bit per i_step
//               cycle. Operates on magnitudes; the caller handles signs.
//               WIDTH steps after i_load, o_quot/o_rem hold the result.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_load          - capture dividend/divisor, clear remainder
//               i_step          - perform one restoring iteration
//               i_dividend      - unsigned dividend magnitude
//               i_divisor       - unsigned divisor magnitude (non-zero)
//               o_quot, o_rem   - quotient and remainder
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);

    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_divisor;

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;

    // The dividend is shifted out of the top of r_quot into the partial
    // remainder while quotient bits are shifted in at the bottom.
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_divisor});
    // When w_ge holds the true difference is below the divisor, so the
    // low WIDTH bits carry it exactly.
    assign w_sub   = w_shift[WIDTH-1:0] - r_divisor;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (i_load) begin
            r_quot    <= i_dividend;
            r_rem     <= '0;
            r_divisor <= i_divisor;
        end else if (i_step) begin
            if (w_ge) begin
                r_rem  <= w_sub;
                r_quot <= {r_quot[WIDTH-2:0], 1'b1};
            end else begin
                r_rem  <= w_shift[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;

endmodule

`default_nettype wire

// File: rtl/mul_div_hilo_unit.sv
// ============================================================================
// Module      : mul_div_hilo_unit
// Description : Iterative multiply / divide unit owning the architectural
//               HI/LO registers. Multiplies are radix-2 shift-add on operand
//               magnitudes followed by a one-cycle sign fixup and HI/LO
//               write (MULT/MULTU/MADD/MSUB). Division uses mdu_divider and
//               is present only when the macro MDU_DIV_EN is defined;
//               otherwise DIV/DIVU complete in one cycle with no effect.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_start         - operation request, sampled in IDLE/DONE
//               i_op            - operation select (see mdu_pkg::op_e)
//               i_a, i_b        - rs/rt operands, captured on accept
//               o_busy          - iterative operation in progress
//               o_done          - one-cycle pulse, HI/LO final
//               o_hi, o_lo      - architectural HI/LO
//               o_div_by_zero   - DIV/DIVU with zero divisor, in Done cycle
// Config      : MDU_DIV_EN      - include the divider
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_hilo_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div_by_zero
);

    localparam int               c_CW       = $clog2(WIDTH);
    localparam logic [c_CW-1:0]  c_CNT_LAST = c_CW'(WIDTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e               r_state;
    op_e                  r_op;
    logic [c_CW-1:0]      r_cnt;
    logic                 r_neg;     // product / quotient is negative
    logic                 r_rneg;    // remainder takes dividend sign
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_prod;    // upper: partial sum, lower: multiplier
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dbz;

    // ------------------------------------------------------------------
    // Operand conditioning at accept
    // ------------------------------------------------------------------
    op_e                  w_op;
    logic                 w_signed;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;

    assign w_op     = op_e'(i_op);
    assign w_signed = op_is_signed(w_op);
    assign w_accept = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    // Magnitude of the most negative value is 2^(WIDTH-1), which still
    // fits as an unsigned WIDTH-bit number.
    assign w_mag_a  = (w_signed && i_a[WIDTH-1]) ? (-i_a) : i_a;
    assign w_mag_b  = (w_signed && i_b[WIDTH-1]) ? (-i_b) : i_b;

    // ------------------------------------------------------------------
    // Shift-add multiply step: conditionally add the multiplicand into the
    // upper half, then shift the whole product right by one. The carry out
    // of the add becomes the new top bit.
    // ------------------------------------------------------------------
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;

    assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                      + {1'b0, (r_prod[0] ? r_mcand : {WIDTH{1'b0}})};
    assign w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

`ifdef MDU_DIV_EN
    logic                 w_div_load;
    logic                 w_div_step;

    assign w_div_load = w_accept && ((w_op == OP_DIV) || (w_op == OP_DIVU)) && (i_b != '0);
    assign w_div_step = (r_state == ST_DIV);

    mdu_divider #(
        .WIDTH      (WIDTH)
    ) u_divider (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_div_load),
        .i_step     (w_div_step),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );
`else
    assign w_quot = '0;
    assign w_rem  = '0;
`endif

    // ------------------------------------------------------------------
    // Sign fixup and HI/LO update value, consumed only in FIX
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [2*WIDTH-1:0]   w_hilo_next;

    always_comb begin
        w_prod_fix  = r_neg  ? (-r_prod) : r_prod;
        w_quot_fix  = r_neg  ? (-w_quot) : w_quot;
        w_rem_fix   = r_rneg ? (-w_rem)  : w_rem;
        w_hilo_next = w_prod_fix;
        case (r_op)
            OP_MADD:          w_hilo_next = {r_hi, r_lo} + w_prod_fix;
            OP_MSUB:          w_hilo_next = {r_hi, r_lo} - w_prod_fix;
            OP_DIV, OP_DIVU:  w_hilo_next = {w_rem_fix, w_quot_fix};
            default:          w_hilo_next = w_prod_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered Busy/Done/DivByZero
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_MULT;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_rneg  <= 1'b0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (w_accept) begin
                        r_op    <= w_op;
                        r_cnt   <= c_CNT_LAST;
                        r_neg   <= w_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        r_rneg  <= w_signed & i_a[WIDTH-1];
                        r_mcand <= w_mag_a;
                        r_prod  <= {{WIDTH{1'b0}}, w_mag_b};
                        case (w_op)
                            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                                r_state <= ST_MUL;
                                r_busy  <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV_EN
                                if (i_b == '0) begin
                                    r_state <= ST_DONE;
                                    r_done  <= 1'b1;
                                    r_dbz   <= 1'b1;
                                end else begin
                                    r_state <= ST_DIV;
                                    r_busy  <= 1'b1;
                                end
`else
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
`endif
                            end
                            OP_MTHI: begin
                                r_hi    <= i_a;
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                            OP_MTLO: begin
                                r_lo    <= i_a;
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                            default: begin
                                r_state <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    r_prod <= w_mul_next;
                    if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DIV: begin
                    // The divider steps itself while in this state.
                    if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    r_hi    <= w_hilo_next[2*WIDTH-1:WIDTH];
                    r_lo    <= w_hilo_next[WIDTH-1:0];
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;
    assign o_div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_hilo_unit.sv
// ============================================================================
// Module      : tb_mul_div_hilo_unit
// Description : Self-checking bench for mul_div_hilo_unit (WIDTH=32).
//               Expectations come from fixed vectors and from an arithmetic
//               reference model of HI/LO. Honours MDU_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_hilo_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [2:0]    i_op;
    logic [W-1:0]  i_a;
    logic [W-1:0]  i_b;
    logic          o_busy;
    logic          o_done;
    logic [W-1:0]  o_hi;
    logic [W-1:0]  o_lo;
    logic          o_div_by_zero;

    int            checks   = 0;
    int            failures = 0;

    logic [W-1:0]  m_hi = '0;
    logic [W-1:0]  m_lo = '0;
    logic          busy_hist [0:127];
    logic          dbz_early;
    logic          dbz_at_done;

    always #5 clk = ~clk;

    mul_div_hilo_unit #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_op          (i_op),
        .i_a           (i_a),
        .i_b           (i_b),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_hi          (o_hi),
        .o_lo          (o_lo),
        .o_div_by_zero (o_div_by_zero)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: HI/LO as one 64-bit value updated with plain arithmetic.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat, output logic dbz);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        logic [63:0]        hl;
        int                 sa;
        int                 sb;
        hl  = {m_hi, m_lo};
        lat = W + 2;
        dbz = 1'b0;
        ps  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        pu  = {32'b0, a} * {32'b0, b};
        sa  = $signed(a);
        sb  = $signed(b);
        case (op)
            3'b000: hl = ps;
            3'b001: hl = pu;
            3'b010: hl = hl + ps;
            3'b011: hl = hl - ps;
            3'b100, 3'b101: begin
`ifdef MDU_DIV_EN
                if (b == 32'd0) begin
                    lat = 1;
                    dbz = 1'b1;
                end else if (op == 3'b101) begin
                    hl = {a % b, a / b};
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    hl = {32'h0, 32'h8000_0000};
                end else begin
                    hl = {32'(sa % sb), 32'(sa / sb)};
                end
`else
                lat = 1;
`endif
            end
            3'b110: begin hl = {a, m_lo}; lat = 1; end
            default: begin hl = {m_hi, a}; lat = 1; end
        endcase
        {m_hi, m_lo} = hl;
    endtask

    // Drives one request and waits (bounded) for Done. Returns at the
    // negedge of the Done cycle, so a b2b call starts in the DONE cycle.
    // inj >= 1 pulses a stray MTHI request in that busy cycle.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit b2b, input int inj, output int lat);
        if (!b2b) @(negedge clk);
        i_start = 1'b1; i_op = op; i_a = a; i_b = b;
        @(negedge clk);
        i_start = 1'b0; i_a = $urandom; i_b = $urandom; i_op = 3'($urandom);
        lat = -1; dbz_early = 1'b0; dbz_at_done = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (k == inj + 1) i_start = 1'b0;
            busy_hist[k] = o_busy;
            if (o_done) begin
                lat = k;
                dbz_at_done = o_div_by_zero;
                break;
            end
            if (o_div_by_zero) dbz_early = 1'b1;
            if (k == inj) begin
                i_start = 1'b1; i_op = 3'b110; i_a = $urandom;
            end
            @(negedge clk);
        end
        i_start = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            4: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; i_start = 1'b0; i_op = '0; i_a = '0; i_b = '0;
        repeat (3) @(negedge clk);
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", o_done); end
        checks++; if (o_div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz: got %b want 0", o_div_by_zero); end
        checks++; if (o_hi !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h want 0", o_hi); end
        checks++; if (o_lo !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h want 0", o_lo); end
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_spec_vectors();
        logic [2:0]  t_op  [0:10];
        logic [31:0] t_a   [0:10];
        logic [31:0] t_b   [0:10];
        logic [31:0] t_hi  [0:10];
        logic [31:0] t_lo  [0:10];
        int          t_lat [0:10];
        logic        t_dbz [0:10];
        int          lat;
        t_op  = '{3'b000, 3'b001, 3'b110, 3'b111, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101, 3'b100};
`ifdef MDU_DIV_EN
        t_a   = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd5, 32'd10, 32'd2, 32'd0, 32'd10, 32'd20,
                  32'hFFFFFFF9, 32'd7, 32'h80000000};
        t_b   = '{32'd7, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd3, 32'd0, 32'd0, 32'd1,
                  32'd2, 32'd0, 32'hFFFFFFFF};
        t_hi  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd5, 32'd5, 32'd5, 32'd0, 32'd0, 32'hFFFFFFFF,
                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        t_lo  = '{32'hFFFFFFEB, 32'h00000001, 32'h1, 32'd10, 32'd16, 32'd16, 32'd10, 32'hFFFFFFF6,
                  32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000};
        t_lat = '{34, 34, 1, 1, 34, 1, 1, 34, 34, 1, 34};
        t_dbz = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
`else
        t_a   = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd5, 32'd10, 32'd2, 32'd0, 32'd10, 32'd20,
                  32'd9, 32'd7, 32'h80000000};
        t_b   = '{32'd7, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd3, 32'd0, 32'd0, 32'd1,
                  32'd3, 32'd0, 32'hFFFFFFFF};
        t_hi  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd5, 32'd5, 32'd5, 32'd0, 32'd0, 32'hFFFFFFFF,
                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        t_lo  = '{32'hFFFFFFEB, 32'h00000001, 32'h1, 32'd10, 32'd16, 32'd16, 32'd10, 32'hFFFFFFF6,
                  32'hFFFFFFF6, 32'hFFFFFFF6, 32'hFFFFFFF6};
        t_lat = '{34, 34, 1, 1, 34, 1, 1, 34, 1, 1, 1};
        t_dbz = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 11; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], 1'b0, -1, lat);
            checks++; if (lat != t_lat[i]) begin failures++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, t_lat[i]); end
            checks++; if (o_hi !== t_hi[i]) begin failures++; $display("FAIL vec%0d_hi: got %h want %h", i, o_hi, t_hi[i]); end
            checks++; if (o_lo !== t_lo[i]) begin failures++; $display("FAIL vec%0d_lo: got %h want %h", i, o_lo, t_lo[i]); end
            checks++; if (dbz_at_done !== t_dbz[i] || dbz_early) begin failures++; $display("FAIL vec%0d_dbz: got %b (early %b) want %b", i, dbz_at_done, dbz_early, t_dbz[i]); end
            if (i == 0) begin
                logic bw;
                bw = 1'b1;
                for (int k = 1; k <= 33; k++) bw = bw & busy_hist[k];
                checks++; if (bw !== 1'b1) begin failures++; $display("FAIL vec0_busy_window: got %b want 1 for cycles 1..33", bw); end
                checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL vec0_busy_at_done: got %b want 0", o_busy); end
                @(negedge clk);
                checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL vec0_done_pulse: got %b want 0 after done", o_done); end
            end
            if (t_op[i] == 3'b110 || t_op[i] == 3'b111) begin
                checks++; if (busy_hist[1] !== 1'b0) begin failures++; $display("FAIL vec%0d_mt_busy: got %b want 0", i, busy_hist[1]); end
            end
            m_hi = t_hi[i]; m_lo = t_lo[i];
        end
    endtask

    task automatic test_busy_ignore();
        int lat, elat;
        logic edbz;
        logic [31:0] a, b;
        for (int j = 0; j < 2; j++) begin
            a = $urandom; b = $urandom;
            model_op(j == 0 ? 3'b000 : 3'b010, a, b, elat, edbz);
            do_op(j == 0 ? 3'b000 : 3'b010, a, b, 1'b0, j == 0 ? 5 : 33, lat);
            checks++; if (lat != elat) begin failures++; $display("FAIL busy_ignore%0d_latency: got %0d want %0d", j, lat, elat); end
            checks++; if (o_hi !== m_hi) begin failures++; $display("FAIL busy_ignore%0d_hi: got %h want %h", j, o_hi, m_hi); end
            checks++; if (o_lo !== m_lo) begin failures++; $display("FAIL busy_ignore%0d_lo: got %h want %h", j, o_lo, m_lo); end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [0:3];
        int lat, elat;
        logic edbz;
        logic [31:0] a, b;
        ops = '{3'b001, 3'b111, 3'b011, 3'b101};
        for (int j = 0; j < 4; j++) begin
            a = $urandom; b = $urandom_range(1, 1000);
            model_op(ops[j], a, b, elat, edbz);
            do_op(ops[j], a, b, j != 0, -1, lat);
            checks++; if (lat != elat) begin failures++; $display("FAIL b2b%0d_latency: got %0d want %0d", j, lat, elat); end
            checks++; if ({o_hi, o_lo} !== {m_hi, m_lo}) begin failures++; $display("FAIL b2b%0d_hilo: got %h_%h want %h_%h", j, o_hi, o_lo, m_hi, m_lo); end
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        logic seen;
        do_op(3'b110, 32'hA5A5_0001, 32'h0, 1'b0, -1, lat);
        do_op(3'b111, 32'h5A5A_0002, 32'h0, 1'b0, -1, lat);
        @(negedge clk);
        i_start = 1'b1; i_op = 3'b000; i_a = 32'd1234; i_b = 32'd5678;
        @(negedge clk);
        i_start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b want 0", o_busy); end
        checks++; if (o_hi !== 32'h0 || o_lo !== 32'h0) begin failures++; $display("FAIL midreset_hilo: got %h_%h want 0_0", o_hi, o_lo); end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            seen = seen | o_done | o_busy;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_no_done: got activity %b want 0", seen); end
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_reset_and_start();
        @(negedge clk);
        rst = 1'b1; i_start = 1'b1; i_op = 3'b110; i_a = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b0; i_start = 1'b0;
        checks++; if (o_hi !== 32'h0) begin failures++; $display("FAIL rst_start_hi: got %h want 0", o_hi); end
        checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL rst_start_ctrl: got done %b busy %b want 0 0", o_done, o_busy); end
        @(negedge clk);
        checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL rst_start_late_done: got %b want 0", o_done); end
    endtask

    task automatic test_random();
        int lat, elat;
        logic edbz;
        logic [2:0]  op;
        logic [31:0] a, b;
        bit b2b;
        for (int n = 0; n < 60; n++) begin
            op  = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            b2b = bit'($urandom_range(0, 1));
            model_op(op, a, b, elat, edbz);
            do_op(op, a, b, b2b, -1, lat);
            checks++; if (lat != elat) begin failures++; $display("FAIL rand%0d_latency op=%0d: got %0d want %0d", n, op, lat, elat); end
            checks++; if (o_hi !== m_hi) begin failures++; $display("FAIL rand%0d_hi op=%0d a=%h b=%h: got %h want %h", n, op, a, b, o_hi, m_hi); end
            checks++; if (o_lo !== m_lo) begin failures++; $display("FAIL rand%0d_lo op=%0d a=%h b=%h: got %h want %h", n, op, a, b, o_lo, m_lo); end
            checks++; if (dbz_at_done !== edbz || dbz_early) begin failures++; $display("FAIL rand%0d_dbz: got %b (early %b) want %b", n, dbz_at_done, dbz_early, edbz); end
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
        test_reset_and_start();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
